ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Bytes queue in a small FIFO. Each byte is sent as one frame:
// request-to-send, start bit, eight data bits (LSB first), odd parity, stop,
// then the device's ACK is sampled. Failed frames are retried after a
// back-off. When the retries run out, err pulses and the whole FIFO is
// flushed so that a partial multi-byte command is never sent.
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRIES    = 2,
  parameter int DEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ps2c_neg,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       full,
  output logic       busy,
  output logic       byte_sent,
  output logic       err,
  output logic [1:0] err_code,
  output logic       overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RTS_LAST  = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  localparam logic [1:0] CODE_NACK    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_SEND,
    ST_DONE,
    ST_FAIL,
    ST_BACKOFF
  } state_t;

  // Power-up values give an idle, empty block even before the first reset.
  state_t          r_state  = ST_IDLE;
  logic [AW:0]     r_wr_ptr = '0;
  logic [AW:0]     r_rd_ptr = '0;
  logic [7:0]      r_mem [DEPTH];
  logic [7:0]      r_byte;
  logic [9:0]      r_shift;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bit_cnt;
  logic [RW-1:0]   r_retry;
  logic [1:0]      r_code;

  state_t          w_state_next;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_ack;
  logic            w_retry_left;
  logic            w_ps2c_low;
  logic            w_ps2d_low;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A push that lands in the same cycle as a flush is discarded with it.
  assign w_push       = wr_en && !w_full && !w_flush;
  // The device ACKs by pulling data low; a released (pulled-up) line is a NACK.
  assign w_ack        = ~ps2d;
  assign w_retry_left = (r_retry < RETRY_MAX);

  // Open-drain pins: state (and the current shift bit) only ever choose
  // between driving 0 and releasing the line.
  assign w_ps2c_low = (r_state == ST_RTS) || (r_state == ST_START);
  assign w_ps2d_low = (r_state == ST_START) || ((r_state == ST_SEND) && !r_shift[0]);
  assign ps2c       = w_ps2c_low ? 1'b0 : 1'bz;
  assign ps2d       = w_ps2d_low ? 1'b0 : 1'bz;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and the status outputs.
  // NOTE: everything written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    byte_sent    = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (!w_empty) w_state_next = ST_RTS;
      ST_RTS:     if (r_cnt == RTS_LAST) w_state_next = ST_START;
      ST_START:   w_state_next = ST_SEND;
      ST_SEND: begin
        if (ps2c_neg) begin
          if (r_bit_cnt == 4'd10) begin
            if (w_ack) w_state_next = ST_DONE;
            else       w_state_next = ST_FAIL;
          end
        end else if (r_cnt == TO_LAST) begin
          w_state_next = ST_FAIL;
        end
      end
      ST_DONE: begin
        w_pop        = 1'b1;
        byte_sent    = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_FAIL: begin
        if (w_retry_left) begin
          w_state_next = ST_BACKOFF;
        end else begin
          err          = 1'b1;
          w_flush      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_BACKOFF: if (r_cnt == RTS_LAST) w_state_next = ST_RTS;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  assign err_code = err ? r_code : 2'b00;
  assign full     = w_full;
  assign busy     = (r_state != ST_IDLE) || !w_empty;
  assign overflow = wr_en && w_full;

  // Frame datapath: shared cycle counter, shift register, bit and retry counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_retry   <= '0;
      r_code    <= 2'b00;
      r_byte    <= '0;
      r_shift   <= '1;
    end else begin
      // One counter times RTS, BACKOFF and the SEND watchdog; it restarts on
      // every state change and on each device clock edge while sending.
      if ((w_state_next != r_state) || ((r_state == ST_SEND) && ps2c_neg)) begin
        r_cnt <= '0;
      end else if ((r_state == ST_RTS) || (r_state == ST_SEND) ||
                   (r_state == ST_BACKOFF)) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      unique case (r_state)
        ST_IDLE: begin
          // Peek at the head; it is only popped once the device ACKs it.
          if (!w_empty) begin
            r_byte  <= r_mem[r_rd_ptr[AW-1:0]];
            r_retry <= '0;
          end
        end
        ST_START: begin
          // Reloaded on every attempt so a retry resends the same frame.
          r_shift   <= {1'b1, ~^r_byte, r_byte, 1'b0};
          r_bit_cnt <= '0;
        end
        ST_SEND: begin
          if (ps2c_neg) begin
            r_shift   <= {1'b1, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          if (w_state_next == ST_FAIL) r_code <= ps2c_neg ? CODE_NACK : CODE_TIMEOUT;
        end
        ST_FAIL: if (w_retry_left) r_retry <= r_retry + 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO pointers: push, pop-on-ACK and flush-on-final-failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_flush)    r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage.
  // NOTE: the array is left out of reset; the pointers alone decide which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, decodes them and compares each against a queue of expected bytes.
module tb_ps2_host_tx;

  localparam int RTS = 100;
  localparam int TMO = 300;
  localparam int DEP = 4;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_STOP4  = 2;
  localparam int M_ABORT6 = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       ps2c_neg  = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       full, busy, byte_sent, err, overflow;
  logic [1:0] err_code;
  wire        ps2c_w;
  wire        ps2d_w;

  int total = 0;
  int bad   = 0;

  int         dev_mode  = M_ACK;
  int         cyc       = 0;
  int         frames    = 0;
  int         sent_cnt  = 0;
  int         err_cnt   = 0;
  int         ovf_cnt   = 0;
  int         gap       = -1;
  int         t_neg     = 0;
  logic       gap_armed = 1'b0;
  logic       dev_busy  = 1'b0;
  logic [1:0] last_code = 2'b00;
  logic [7:0] exp_q [$];
  logic [7:0] burst [5];

  pullup (ps2c_w);
  pullup (ps2d_w);
  assign ps2d_w = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (2),
    .DEPTH         (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ps2c_neg (ps2c_neg),
    .ps2c     (ps2c_w),
    .ps2d     (ps2d_w),
    .full     (full),
    .busy     (busy),
    .byte_sent(byte_sent),
    .err      (err),
    .err_code (err_code),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk); #2;
    if (byte_sent === 1'b1) sent_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      last_code = err_code;
    end
    if (overflow === 1'b1) ovf_cnt++;
  end

  // Device model: waits for request-to-send, clocks the frame, checks it.
  initial begin : device
    int         rts_len;
    int         nneg;
    logic [10:0] bits;
    logic [7:0]  eb;
    rts_len = 0;
    forever begin
      @(negedge clk);
      if (ps2c_w === 1'b0 && ps2d_w === 1'b1) begin
        if (rts_len == 0 && gap_armed) begin
          gap       = cyc - t_neg;
          gap_armed = 1'b0;
        end
        rts_len++;
      end else if (ps2c_w === 1'b0 && ps2d_w === 1'b0) begin
        dev_busy = 1'b1;
        frames++;
        check("rts_len", rts_len, RTS);
        rts_len = 0;
        @(negedge clk);
        check("start_clk_released", ps2c_w, 1);
        check("start_bit", ps2d_w, 0);
        nneg = (dev_mode == M_STOP4) ? 4 : ((dev_mode == M_ABORT6) ? 6 : 11);
        bits = '1;
        for (int k = 1; k <= nneg; k++) begin
          repeat (3) @(negedge clk);
          if (k == 11 && dev_mode == M_ACK) begin
            dev_d_low = 1'b1;
            repeat (2) @(negedge clk);
          end
          ps2c_neg = 1'b1;
          if (dev_mode == M_ABORT6 && k == 6) rst = 1'b1;
          t_neg = cyc;
          @(negedge clk);
          ps2c_neg  = 1'b0;
          dev_d_low = 1'b0;
          if (dev_mode == M_ABORT6 && k == 6) begin
            #1;
            check("rst_ps2c_released", ps2c_w, 1);
            check("rst_ps2d_released", ps2d_w, 1);
            check("rst_busy", busy, 0);
            check("rst_byte_sent", byte_sent, 0);
            check("rst_err", err, 0);
            rst = 1'b0;
          end else if (k <= 10) begin
            bits[k] = (ps2d_w === 1'b1);
          end
        end
        if (dev_mode == M_STOP4) gap_armed = 1'b1;
        if (nneg == 11) begin
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check("data", bits[8:1], eb);
            check("parity", bits[9], ~^eb);
            check("stop", bits[10], 1);
          end
        end
        dev_busy = 1'b0;
      end else begin
        rts_len = 0;
      end
    end
  end

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = burst[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while ((busy !== 1'b0 || dev_busy) && n < budget);
    check(tag, (busy === 1'b0) && !dev_busy, 1);
    repeat (2) @(negedge clk);
  endtask

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation guard expired");
  end

  initial begin : main
    int s0, e0, f0, o0, n;

    // Power-up state before any reset.
    @(negedge clk); #1;
    check("pwr_busy", busy, 0);
    check("pwr_ps2c", ps2c_w, 1);

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ps2c", ps2c_w, 1);
    check("rst_ps2d", ps2d_w, 1);
    check("rst_busy0", busy, 0);
    check("rst_full", full, 0);
    check("rst_sent", byte_sent, 0);
    check("rst_err0", err, 0);
    check("rst_code", err_code, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Single byte 0xED, ACKed.
    s0 = sent_cnt; e0 = err_cnt; f0 = frames;
    dev_mode = M_ACK;
    exp_q.push_back(8'hED);
    burst[0] = 8'hED;
    push_burst(1);
    wait_idle("ed_idle", 1000);
    check("ed_sent", sent_cnt - s0, 1);
    check("ed_frames", frames - f0, 1);
    check("ed_err", err_cnt - e0, 0);
    check("ed_q_empty", exp_q.size(), 0);

    // 0xED then 0x02 back-to-back.
    s0 = sent_cnt; f0 = frames;
    exp_q.push_back(8'hED);
    exp_q.push_back(8'h02);
    burst[0] = 8'hED;
    burst[1] = 8'h02;
    push_burst(2);
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (sent_cnt < s0 + 1 && n < 1000);
    check("two_first_sent", sent_cnt - s0, 1);
    @(negedge clk); #1;
    check("two_busy_between", busy, 1);
    wait_idle("two_idle", 2000);
    check("two_sent", sent_cnt - s0, 2);
    check("two_frames", frames - f0, 2);
    check("two_busy_after", busy, 0);
    check("two_q_empty", exp_q.size(), 0);

    // 0xFF NACKed on every attempt, with a trailing byte that must be flushed.
    s0 = sent_cnt; e0 = err_cnt; f0 = frames;
    dev_mode = M_NACK;
    repeat (3) exp_q.push_back(8'hFF);
    burst[0] = 8'hFF;
    burst[1] = 8'h55;
    push_burst(2);
    wait_idle("nack_idle", 3000);
    repeat (50) @(negedge clk);
    check("nack_frames", frames - f0, 3);
    check("nack_err", err_cnt - e0, 1);
    check("nack_code", last_code, 2'b01);
    check("nack_sent", sent_cnt - s0, 0);
    check("nack_flushed", busy, 0);
    check("nack_full", full, 0);
    check("nack_q_empty", exp_q.size(), 0);

    // Device stops clocking after the 4th falling edge.
    s0 = sent_cnt; e0 = err_cnt; f0 = frames;
    dev_mode = M_STOP4;
    gap = -1;
    burst[0] = 8'h12;
    push_burst(1);
    wait_idle("tmo_idle", 5000);
    gap_armed = 1'b0;
    check("tmo_frames", frames - f0, 3);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_code", last_code, 2'b10);
    check("tmo_sent", sent_cnt - s0, 0);
    check("tmo_retry_gap", (gap >= TMO + RTS) && (gap <= TMO + RTS + 4), 1);

    // Five pushes in consecutive cycles into a 4-deep FIFO.
    s0 = sent_cnt; o0 = ovf_cnt;
    dev_mode = M_ACK;
    burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'h00;
    burst[3] = 8'h81; burst[4] = 8'h99;
    for (int i = 0; i < 4; i++) exp_q.push_back(burst[i]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = burst[i];
      #1;
      if (i == 3) check("burst_not_full_at_3", full, 0);
      if (i == 4) begin
        check("burst_full_at_4", full, 1);
        check("burst_ovf_on_5th", overflow, 1);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("burst_ovf_cleared", overflow, 0);
    wait_idle("burst_idle", 4000);
    check("burst_sent", sent_cnt - s0, 4);
    check("burst_ovf_cnt", ovf_cnt - o0, 1);
    check("burst_q_empty", exp_q.size(), 0);

    // Reset asserted at the 6th falling edge of a frame.
    s0 = sent_cnt; e0 = err_cnt; f0 = frames;
    dev_mode = M_ABORT6;
    burst[0] = 8'h77;
    push_burst(1);
    wait_idle("abort_idle", 1000);
    repeat (20) @(negedge clk);
    #1;
    check("abort_frames", frames - f0, 1);
    check("abort_sent", sent_cnt - s0, 0);
    check("abort_err", err_cnt - e0, 0);
    check("abort_busy", busy, 0);
    check("abort_ps2c", ps2c_w, 1);
    check("abort_ps2d", ps2d_w, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
